// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - RAW hazard tracking, stall generation and EX forwarding selects
// Tracks EX/MEM/WB destinations and stalls the decode stage on unresolvable hazards.
`timescale 1ns/1ps
module hazard_scoreboard #(
  parameter bit FORWARD = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic [4:0]       id_rd,
  input  logic             id_reg_dst,
  input  logic             id_reg_write,
  input  logic             id_mem_to_reg,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       ex_fwd_a,
  output logic [1:0]       ex_fwd_b,
  output logic [4:0]       ex_dst,
  output logic [4:0]       mem_dst,
  output logic [4:0]       wb_dst,
  output logic             ex_wr,
  output logic             mem_wr,
  output logic             wb_wr,
  output logic [CNT_W-1:0] stall_count
);

  logic       ex_load;
  logic [4:0] id_dst;
  logic       new_wr;
  logic       rs_ex, rt_ex, rs_mem, rt_mem;
  logic       active;
  logic       advance;
  logic [1:0] fwd_a_nxt, fwd_b_nxt;

  // *_wr is only ever set for a non-zero destination, so register 0 can never match.
  always_comb begin
    id_dst = id_reg_dst ? id_rd : id_rt;
    new_wr = id_valid & id_reg_write & (id_dst != 5'd0);
    rs_ex  = id_rs_used & ex_wr  & (id_rs == ex_dst);
    rt_ex  = id_rt_used & ex_wr  & (id_rt == ex_dst);
    rs_mem = id_rs_used & mem_wr & (id_rs == mem_dst);
    rt_mem = id_rt_used & mem_wr & (id_rt == mem_dst);
    active = id_valid & ~flush;
    if (FORWARD)
      stall = active & ex_load & (rs_ex | rt_ex);
    else
      stall = active & (rs_ex | rt_ex | rs_mem | rt_mem);
    advance = id_valid & ~stall & ~flush;
  end

  always_comb begin
    fwd_a_nxt = 2'b00;
    fwd_b_nxt = 2'b00;
    if (FORWARD && advance) begin
      if (rs_ex)       fwd_a_nxt = 2'b10;
      else if (rs_mem) fwd_a_nxt = 2'b01;
      if (rt_ex)       fwd_b_nxt = 2'b10;
      else if (rt_mem) fwd_b_nxt = 2'b01;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_dst      <= 5'd0;
      ex_wr       <= 1'b0;
      ex_load     <= 1'b0;
      mem_dst     <= 5'd0;
      mem_wr      <= 1'b0;
      wb_dst      <= 5'd0;
      wb_wr       <= 1'b0;
      ex_fwd_a    <= 2'b00;
      ex_fwd_b    <= 2'b00;
      stall_count <= '0;
    end else begin
      wb_dst   <= mem_dst;
      wb_wr    <= mem_wr;
      mem_dst  <= ex_dst;
      mem_wr   <= ex_wr;
      ex_fwd_a <= fwd_a_nxt;
      ex_fwd_b <= fwd_b_nxt;
      if (advance && new_wr) begin
        ex_dst  <= id_dst;
        ex_wr   <= 1'b1;
        ex_load <= id_mem_to_reg;
      end else begin
        ex_dst  <= 5'd0;
        ex_wr   <= 1'b0;
        ex_load <= 1'b0;
      end
      if (stall && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed self-checking bench for hazard_scoreboard
// Runs a forwarding and a non-forwarding instance side by side on shared stimulus.
`timescale 1ns/1ps
module tb_hazard_scoreboard;

  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_rs_used, id_rt_used, id_reg_dst, id_reg_write, id_mem_to_reg, flush;
  logic [4:0] id_rs, id_rt, id_rd;

  logic        f_stall, f_ex_wr, f_mem_wr, f_wb_wr;
  logic [1:0]  f_fwd_a, f_fwd_b;
  logic [4:0]  f_ex_dst, f_mem_dst, f_wb_dst;
  logic [15:0] f_cnt;
  logic        n_stall, n_ex_wr, n_mem_wr, n_wb_wr;
  logic [1:0]  n_fwd_a, n_fwd_b;
  logic [4:0]  n_ex_dst, n_mem_dst, n_wb_dst;
  logic [15:0] n_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.FORWARD(1'b1), .CNT_W(16)) u_fwd (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd),
    .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
    .flush(flush), .stall(f_stall), .ex_fwd_a(f_fwd_a), .ex_fwd_b(f_fwd_b),
    .ex_dst(f_ex_dst), .mem_dst(f_mem_dst), .wb_dst(f_wb_dst),
    .ex_wr(f_ex_wr), .mem_wr(f_mem_wr), .wb_wr(f_wb_wr), .stall_count(f_cnt)
  );

  hazard_scoreboard #(.FORWARD(1'b0), .CNT_W(16)) u_nofwd (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd),
    .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
    .flush(flush), .stall(n_stall), .ex_fwd_a(n_fwd_a), .ex_fwd_b(n_fwd_b),
    .ex_dst(n_ex_dst), .mem_dst(n_mem_dst), .wb_dst(n_wb_dst),
    .ex_wr(n_ex_wr), .mem_wr(n_mem_wr), .wb_wr(n_wb_wr), .stall_count(n_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic rsu, input logic rtu, input logic [4:0] rd,
                       input logic rdst, input logic rw, input logic m2r);
    id_valid = v; id_rs = rs; id_rt = rt; id_rs_used = rsu; id_rt_used = rtu;
    id_rd = rd; id_reg_dst = rdst; id_reg_write = rw; id_mem_to_reg = m2r;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    idle();
    #12;
    check("reset_stall", f_stall, 0);
    check("reset_ex_wr", f_ex_wr, 0);
    check("reset_cnt", f_cnt, 0);
    rst = 1'b0;
    tick();

    // FORWARD=1 back-to-back ALU: add r5, then two consumers of r5
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
    check("alu_prod_stall", f_stall, 0);
    tick();
    check("alu_ex_dst", f_ex_dst, 5);
    check("alu_ex_wr", f_ex_wr, 1);
    drive(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0);
    check("alu_cons1_stall", f_stall, 0);
    check("nofwd_cons1_stall", n_stall, 1);
    tick();
    check("alu_cons1_fwd_a", f_fwd_a, 2'b10);
    check("alu_mem_dst", f_mem_dst, 5);
    drive(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
    tick();
    check("alu_cons2_fwd_a", f_fwd_a, 2'b01);
    check("alu_wb_dst", f_wb_dst, 5);
    check("alu_wb_wr", f_wb_wr, 1);
    check("alu_ex_dst7", f_ex_dst, 7);

    // asynchronous reset with all three entries valid, no clock edge
    idle();
    rst = 1'b1;
    #1;
    check("amid_ex_wr", f_ex_wr, 0);
    check("amid_mem_wr", f_mem_wr, 0);
    check("amid_wb_wr", f_wb_wr, 0);
    check("amid_wb_dst", f_wb_dst, 0);
    check("amid_fwd_a", f_fwd_a, 0);
    check("amid_nofwd_cnt", n_cnt, 0);
    #2;
    rst = 1'b0;
    tick();

    // FORWARD=1 load-use: lw r8, then consumer reading rt=8
    drive(1'b1, 5'd1, 5'd8, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    check("lu_lw_stall", f_stall, 0);
    tick();
    drive(1'b1, 5'd0, 5'd8, 1'b0, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0);
    check("lu_stall_on", f_stall, 1);
    tick();
    check("lu_bubble_ex_wr", f_ex_wr, 0);
    check("lu_mem_dst", f_mem_dst, 8);
    check("lu_cnt1", f_cnt, 1);
    check("lu_stall_off", f_stall, 0);
    tick();
    check("lu_fwd_b", f_fwd_b, 2'b01);
    check("lu_ex_dst", f_ex_dst, 9);
    check("lu_wb_dst", f_wb_dst, 8);
    check("lu_cnt_still1", f_cnt, 1);
    idle();
    tick();
    check("lu_wb_gone", f_wb_wr, 0);

    // register 0 destination and unused source
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 1'b1);
    tick();
    check("r0_ex_wr", f_ex_wr, 0);
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd4, 1'b1, 1'b1, 1'b1);
    check("r0_cons_stall", f_stall, 0);
    tick();
    drive(1'b1, 5'd4, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    check("unused_stall", f_stall, 0);
    tick();
    check("unused_fwd_a", f_fwd_a, 0);
    check("unused_fwd_b", f_fwd_b, 0);

    // flush beats a load-use stall
    drive(1'b1, 5'd0, 5'd10, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    tick();
    drive(1'b1, 5'd10, 5'd0, 1'b1, 1'b0, 5'd11, 1'b1, 1'b1, 1'b0);
    check("fl_hazard_present", f_stall, 1);
    flush = 1'b1;
    #1;
    check("fl_stall_masked", f_stall, 0);
    tick();
    check("fl_bubble_ex_wr", f_ex_wr, 0);
    check("fl_mem_dst", f_mem_dst, 10);
    check("fl_cnt_unchanged", f_cnt, 1);
    flush = 1'b0;
    idle();

    // FORWARD=0: producer r3 then immediate consumer of r3
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd12, 1'b1, 1'b1, 1'b0);
    check("nf_stall_ex", n_stall, 1);
    check("nf_fwd_side_stall", f_stall, 0);
    tick();
    check("nf_bubble", n_ex_wr, 0);
    check("nf_mem_dst", n_mem_dst, 3);
    check("nf_stall_mem", n_stall, 1);
    check("nf_cnt1", n_cnt, 1);
    tick();
    check("nf_cnt2", n_cnt, 2);
    check("nf_stall_clear", n_stall, 0);
    tick();
    check("nf_ex_dst", n_ex_dst, 12);
    check("nf_ex_wr", n_ex_wr, 1);
    check("nf_fwd_a", n_fwd_a, 2'b00);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
